coffee_dispense_ctrl: RTL

- Sequences the physical dispensing hardware downstream of the coin-acceptor FSM.
- Each one-cycle `coffee` pulse from the acceptor is counted as a pending order in vend_req.
- Orders are served one at a time: heater check, cup drop, cup detect, timed pour, cup removal.
- Faults (no cup, cup pulled mid-pour) freeze dispensing until cleared by the operator. Pending orders are kept.

---
 rtl/coffee_dispense_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/coffee_dispense_ctrl.sv
// Dispense sequencer behind the coin acceptor: queues orders, then runs
// heater check, cup drop, cup detect, timed pour and cup removal per order.
module coffee_dispense_ctrl #(
    parameter int unsigned CUP_CYCLES     = 4,
    parameter int unsigned POUR_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned MAX_PENDING    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vend_req,
    input  logic       heater_ready,
    input  logic       cup_present,
    input  logic       fault_clr,
    output logic       cup_drop,
    output logic       valve_open,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       overflow,
    output logic [1:0] pending
);

    localparam int unsigned TMR_MAX_A = (CUP_CYCLES > POUR_CYCLES) ? CUP_CYCLES : POUR_CYCLES;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYCLES) ? TMR_MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam int unsigned PEND_W    = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HEAT,
        S_DROP_CUP,
        S_WAIT_CUP,
        S_POUR,
        S_REMOVE,
        S_FAULT
    } state_t;

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic [PEND_W-1:0]   r_pending;
    logic                r_done;
    logic                r_overflow;
    logic                w_start;

    // An order is taken off the queue only when the cup drop actually begins.
    assign w_start = heater_ready &&
                     (((r_state == S_IDLE) && (r_pending != '0)) || (r_state == S_WAIT_HEAT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_pending  <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_DROP_CUP;
                        r_timer <= '0;
                    end else if (r_pending != '0) begin
                        r_state <= S_WAIT_HEAT;
                    end
                end
                S_WAIT_HEAT: begin
                    if (w_start) begin
                        r_state <= S_DROP_CUP;
                        r_timer <= '0;
                    end
                end
                S_DROP_CUP: begin
                    if (r_timer == TMR_W'(CUP_CYCLES - 1)) begin
                        r_state <= S_WAIT_CUP;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_WAIT_CUP: begin
                    if (cup_present) begin
                        r_state <= S_POUR;
                        r_timer <= '0;
                    end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= S_FAULT;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_POUR: begin
                    // Losing the cup mid-pour wins over normal completion.
                    if (!cup_present) begin
                        r_state <= S_FAULT;
                        r_timer <= '0;
                    end else if (r_timer == TMR_W'(POUR_CYCLES - 1)) begin
                        r_state <= S_REMOVE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_REMOVE: begin
                    if (!cup_present) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase

            // Simultaneous order and start cancel out; a full queue drops the order.
            if (vend_req && !w_start) begin
                if (r_pending == PEND_W'(MAX_PENDING)) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + PEND_W'(1);
                end
            end else if (!vend_req && w_start) begin
                r_pending <= r_pending - PEND_W'(1);
            end
        end
    end

    assign cup_drop   = (r_state == S_DROP_CUP);
    assign valve_open = (r_state == S_POUR);
    assign fault      = (r_state == S_FAULT);
    assign busy       = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign pending    = r_pending;

endmodule
